// File: rtl/ibex_probe_pkg.sv
// Shared definitions for the Ibex probe responder: FSM state encoding and
// default parameter values.
package ibex_probe_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_SLEEP  = 3'd3,
      ST_DEBUG  = 3'd4,
      ST_LOCKED = 3'd5
   } state_t;

   localparam int unsigned DEF_SLEEP_DRAIN_CYCLES = 2;
   localparam int unsigned DEF_ALERT_CNT_W        = 8;

   // Drain counter width; it covers the legal SleepDrainCycles range 1..15.
   localparam int unsigned DRAIN_CNT_W = 4;

endpackage

// File: rtl/ibex_probe_sat_cnt.sv
// Saturating up-counter: counts inc pulses and holds at all-ones, never wraps.
module ibex_probe_sat_cnt #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [Width-1:0] cnt
);

   // Count up on each inc until every bit is set, then hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ibex_probe_responder.sv
// Ibex probe responder: emulates core sleep/debug/lock behaviour for a bench.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | out of reset, waiting for fetch_enable_i
// RUN    | core executing; accepts WFI, ECALL and debug requests
// DRAIN  | WFI accepted, counting down before the core is reported asleep
// SLEEP  | core asleep until wake_i or debug_req_i
// DEBUG  | debug mode, left only by DRET
// LOCKED | major fault seen; left only by reset
module ibex_probe_responder
   import ibex_probe_pkg::*;
#(
   parameter int unsigned SleepDrainCycles = DEF_SLEEP_DRAIN_CYCLES,
   parameter int unsigned AlertCntW        = DEF_ALERT_CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 fetch_enable_i,
   input  logic                 debug_req_i,
   input  logic                 wfi_i,
   input  logic                 wake_i,
   input  logic                 dret_i,
   input  logic                 ecall_insn_i,
   input  logic                 fault_minor_i,
   input  logic                 fault_major_i,
   output logic                 core_sleep_o,
   output logic                 alert_minor_o,
   output logic                 alert_major_o,
   output logic                 ecall_o,
   output logic                 debug_mode_o,
   output logic [AlertCntW-1:0] alert_minor_cnt_o
);

   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(SleepDrainCycles - 1);

   state_t                 state, state_next;
   logic [DRAIN_CNT_W-1:0] drain_cnt, drain_cnt_next;
   logic                   ecall_fire;

   // State and drain-counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
      end else begin
         state     <= state_next;
         drain_cnt <= drain_cnt_next;
      end
   end

   // Next-state logic; branch order encodes the per-cycle event priority.
   always_comb begin
      state_next     = state;
      drain_cnt_next = drain_cnt;
      ecall_fire     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (fetch_enable_i) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (fault_major_i)    state_next = ST_LOCKED;
            else if (debug_req_i) state_next = ST_DEBUG;
            else if (wake_i)      state_next = ST_RUN;
            else if (wfi_i) begin
               state_next     = ST_DRAIN;
               drain_cnt_next = DRAIN_LOAD;
            end else if (ecall_insn_i) begin
               ecall_fire = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (fault_major_i)         state_next = ST_LOCKED;
            else if (debug_req_i)      state_next = ST_DEBUG;
            else if (wake_i)           state_next = ST_RUN;
            else if (drain_cnt == '0)  state_next = ST_SLEEP;
            else                       drain_cnt_next = drain_cnt - 1'b1;
         end
         ST_SLEEP: begin
            if (fault_major_i)    state_next = ST_LOCKED;
            else if (debug_req_i) state_next = ST_DEBUG;
            else if (wake_i)      state_next = ST_RUN;
         end
         ST_DEBUG: begin
            if (fault_major_i) state_next = ST_LOCKED;
            else if (dret_i)   state_next = ST_RUN;
         end
         ST_LOCKED: begin
            state_next = ST_LOCKED;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Registered outputs, derived from the upcoming state so they align with it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         core_sleep_o  <= 1'b0;
         debug_mode_o  <= 1'b0;
         alert_major_o <= 1'b0;
         ecall_o       <= 1'b0;
         alert_minor_o <= 1'b0;
      end else begin
         core_sleep_o  <= (state_next == ST_SLEEP);
         debug_mode_o  <= (state_next == ST_DEBUG);
         alert_major_o <= alert_major_o | (state_next == ST_LOCKED);
         ecall_o       <= ecall_fire;
         alert_minor_o <= fault_minor_i;
      end
   end

   // Counter steps on the same edge that raises alert_minor_o.
   ibex_probe_sat_cnt #(
      .Width (AlertCntW)
   ) u_alert_cnt (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .inc   (fault_minor_i),
      .cnt   (alert_minor_cnt_o)
   );

endmodule

// File: doc/ibex_probe_responder.md
IBEX_PROBE_RESPONDER -- requirements
Module: ibex_probe_responder

Interface
REQ-001 Parameter SleepDrainCycles, default 2, meaning cycles spent in DRAIN between WFI acceptance and core_sleep_o assertion (legal 1..15).
REQ-002 Parameter AlertCntW, default 8, meaning width of the saturating minor-alert counter.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 fetch_enable_i  input  1  bench fetch permission, the probe's fetch_enable.
REQ-006 debug_req_i  input  1  bench debug request, level-sensitive.
REQ-007 wfi_i  input  1  core retires WFI this cycle.
REQ-008 wake_i  input  1  pending enabled interrupt.
REQ-009 dret_i  input  1  core retires DRET this cycle.
REQ-010 ecall_insn_i  input  1  core retires ECALL this cycle.
REQ-011 fault_minor_i  input  1  minor fault event this cycle.
REQ-012 fault_major_i  input  1  major fault event this cycle.
REQ-013 core_sleep_o  output  1  core asleep, the probe's core_sleep.
REQ-014 alert_minor_o  output  1  one-cycle minor alert pulse.
REQ-015 alert_major_o  output  1  sticky major alert.
REQ-016 ecall_o  output  1  one-cycle ECALL pulse.
REQ-017 debug_mode_o  output  1  high while in DEBUG.
REQ-018 alert_minor_cnt_o  output  AlertCntW  saturating count of minor alerts.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN, SLEEP, DEBUG, LOCKED; all outputs registered.
REQ-020 IDLE -> RUN when fetch_enable_i=1; fetch_enable_i is ignored in all other states.
REQ-021 RUN -> DRAIN on wfi_i, loading drain counter with SleepDrainCycles-1; DRAIN decrements each cycle and -> SLEEP the cycle after counter reaches 0.
REQ-022 core_sleep_o SHALL be 1 exactly in SLEEP, first high SleepDrainCycles+1 cycles after the wfi_i cycle.
REQ-023 SLEEP -> RUN on wake_i; SLEEP -> DEBUG on debug_req_i (debug wins if both); wake_i in DRAIN aborts to RUN.
REQ-024 RUN or DRAIN -> DEBUG on debug_req_i; DEBUG -> RUN on dret_i; debug_mode_o=1 exactly in DEBUG.
REQ-025 Any state except IDLE -> LOCKED on fault_major_i; LOCKED exits only via reset; alert_major_o rises the cycle after and stays 1.
REQ-026 Per-cycle priority: fault_major_i > debug_req_i > wake_i > wfi_i > ecall_insn_i.
REQ-027 ecall_o SHALL pulse one cycle, one cycle after ecall_insn_i, only if the FSM was in RUN and no higher-priority event occurred that cycle.
REQ-028 alert_minor_o SHALL pulse one cycle after each fault_minor_i in any state, including LOCKED; back-to-back inputs give back-to-back pulses.
REQ-029 alert_minor_cnt_o increments with each alert_minor_o pulse, saturating at all-ones with no wrap.
REQ-030 Inputs wfi_i, dret_i, ecall_insn_i SHALL be ignored outside the states named above.

Reset
REQ-031 Reset SHALL force IDLE, drain counter 0, all outputs 0, asynchronously, including mid-DRAIN or LOCKED.
REQ-032 After rst_ni release, the first transition SHALL require fetch_enable_i sampled high on a clock edge.

Structure
REQ-033 State enum and default parameter values SHALL live in shared package ibex_probe_pkg.
REQ-034 The saturating counter SHALL be sub-module ibex_probe_sat_cnt; FSM stays in the top.

Verification
REQ-035 fetch_enable_i=1 at cycle 2, wfi_i at cycle 5, SleepDrainCycles=2 -> core_sleep_o high from cycle 8; wake_i at 12 -> low at 13.
REQ-036 In SLEEP, debug_req_i and wake_i same cycle -> debug_mode_o=1 next cycle, core_sleep_o=0; dret_i -> RUN, debug_mode_o=0.
REQ-037 ecall_insn_i and debug_req_i same cycle in RUN -> ecall_o stays 0, debug_mode_o=1.
REQ-038 300 consecutive fault_minor_i cycles, AlertCntW=8 -> 300 alert_minor_o pulses, alert_minor_cnt_o=255.
REQ-039 fault_major_i in DRAIN -> alert_major_o sticky 1, wake_i/debug_req_i ignored; rst_ni low -> all outputs 0 immediately, state IDLE.
